// File: rtl/pet_pkg.sv
// Shared types and helpers for the virtual-pet need controller: state encoding,
// display-code mapping and the width helpers used on its ports.
package pet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MILD = 3'd1,
    ST_CRIT = 3'd2,
    ST_ACT  = 3'd3,
    ST_DEAD = 3'd4
  } pet_state_t;

  function automatic int unsigned vis_width(input int unsigned n_needs);
    return $clog2(3 * n_needs + 2);
  endfunction

  function automatic int unsigned need_width(input int unsigned n_needs);
    return (n_needs > 1) ? $clog2(n_needs) : 1;
  endfunction

  function automatic int unsigned vis_code(input pet_state_t s, input int unsigned need,
                                           input int unsigned n_needs);
    case (s)
      ST_IDLE: return 0;
      ST_MILD: return 1 + 3 * need;
      ST_CRIT: return 2 + 3 * need;
      ST_ACT:  return 3 + 3 * need;
      ST_DEAD: return 3 * n_needs + 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/step_sync.sv
// Two-flop synchroniser followed by a rising-edge detector for an asynchronous
// strobe; rise_o is a single-cycle pulse per clean rising edge of async_i.
module step_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic sync1, sync2, prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= async_i;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise_o = sync2 & ~prev;

endmodule

// File: rtl/pet_need_fsm.sv
// Virtual-pet behaviour controller: tracks the most urgent of N_NEEDS levels,
// escalates warning/critical/action states, starves into DEAD, and supports a
// synchronised single-step test sequence.
//
//   state | meaning
//   IDLE  | all needs satisfied, watching for a low level
//   MILD  | latched need is low (below WARN_TH)
//   CRIT  | latched need is critical; ccnt counts toward starvation
//   ACT   | action held on the latched need; actuators disabled
//   DEAD  | starved; absorbing until reset
module pet_need_fsm
  import pet_pkg::*;
#(
  parameter int N_NEEDS   = 4,
  parameter int LVL_W     = 2,
  parameter int WARN_TH   = 3,
  parameter int CRIT_TH   = 1,
  parameter int DEATH_CYC = 1024
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_NEEDS*LVL_W-1:0]            level_i,
  input  logic [N_NEEDS-1:0]                  action_i,
  input  logic                                test_mode_i,
  input  logic                                test_step_i,
  output logic [vis_width(N_NEEDS)-1:0]       vis_o,
  output logic [need_width(N_NEEDS)-1:0]      need_o,
  output logic [N_NEEDS-1:0]                  act_en_o,
  output logic                                dead_o
);

  localparam int VIS_W  = vis_width(N_NEEDS);
  localparam int NEED_W = need_width(N_NEEDS);
  localparam int CNT_W  = $clog2(DEATH_CYC);

  localparam logic [LVL_W:0]  WARN_V    = (LVL_W + 1)'(WARN_TH);
  localparam logic [LVL_W:0]  CRIT_V    = (LVL_W + 1)'(CRIT_TH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEATH_CYC - 1);
  localparam logic [NEED_W-1:0] NEED_LAST = NEED_W'(N_NEEDS - 1);

  pet_state_t        state_q, state_d;
  logic [NEED_W-1:0] need_q, need_d;
  logic [CNT_W-1:0]  ccnt_q, ccnt_d;

  logic              step_rise;
  logic [LVL_W-1:0]  lvl [N_NEEDS];
  logic [LVL_W-1:0]  cur_lvl;
  logic              any_low;
  logic [NEED_W-1:0] low_idx;
  logic              l_crit, l_max, act;

  step_sync u_step_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (test_step_i),
    .rise_o  (step_rise)
  );

  always_comb begin
    for (int i = 0; i < N_NEEDS; i++) begin
      lvl[i] = level_i[i*LVL_W +: LVL_W];
    end
  end

  // Scan from the top so the lowest low index is the one left standing.
  always_comb begin
    any_low = 1'b0;
    low_idx = '0;
    for (int i = N_NEEDS - 1; i >= 0; i--) begin
      if ({1'b0, lvl[i]} < WARN_V) begin
        any_low = 1'b1;
        low_idx = NEED_W'(i);
      end
    end
  end

  assign cur_lvl = lvl[need_q];
  assign l_crit  = ({1'b0, cur_lvl} < CRIT_V);
  assign l_max   = &cur_lvl;
  assign act     = action_i[need_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      need_q  <= '0;
      ccnt_q  <= '0;
    end else begin
      state_q <= state_d;
      need_q  <= need_d;
      ccnt_q  <= ccnt_d;
    end
  end

  // ccnt is only non-zero while sitting in CRIT in normal mode.
  always_comb begin
    state_d = state_q;
    need_d  = need_q;
    ccnt_d  = '0;
    if (test_mode_i) begin
      if (step_rise) begin
        case (state_q)
          ST_IDLE: state_d = ST_MILD;
          ST_MILD: state_d = ST_CRIT;
          ST_CRIT: state_d = ST_ACT;
          ST_ACT: begin
            state_d = ST_IDLE;
            need_d  = (need_q == NEED_LAST) ? '0 : need_q + NEED_W'(1);
          end
          default: state_d = state_q;
        endcase
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_low) begin
            state_d = ST_MILD;
            need_d  = low_idx;
          end
        end
        ST_MILD: begin
          if (l_crit)   state_d = ST_CRIT;
          else if (act) state_d = ST_ACT;
        end
        ST_CRIT: begin
          if (act)                     state_d = ST_ACT;
          else if (ccnt_q == CNT_LAST) state_d = ST_DEAD;
          else                         ccnt_d  = ccnt_q + CNT_W'(1);
        end
        ST_ACT: begin
          if (!act) begin
            if (l_max)       state_d = ST_IDLE;
            else if (!l_crit) state_d = ST_MILD;
            else             state_d = ST_CRIT;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign vis_o    = VIS_W'(vis_code(state_q, 32'(need_q), N_NEEDS));
  assign need_o   = need_q;
  assign act_en_o = (state_q == ST_ACT || state_q == ST_DEAD) ? '0 : '1;
  assign dead_o   = (state_q == ST_DEAD);

endmodule
